// File: rtl/seq_decoder_pkg.sv
// -----------------------------------------------------------------------------
// seq_decoder_pkg
//
// Purpose:
//   Shared definitions for the sequential one-hot decoder and its helpers:
//   the control state type and the symbolic values of the mode and scan
//   direction inputs.
//
// Contents:
//   state_t      - decoder control state (IDLE, DIRECT, SCAN)
//   MODE_DIRECT  - mode input value selecting direct decode
//   MODE_SCAN    - mode input value selecting free-running scan
//   DIR_UP       - dir input value: scan index increments
//   DIR_DOWN     - dir input value: scan index decrements
// -----------------------------------------------------------------------------
package seq_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   localparam logic DIR_UP      = 1'b0;
   localparam logic DIR_DOWN    = 1'b1;

endpackage : seq_decoder_pkg

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//
// Purpose:
//   Free-running DIV_W-bit prescaler. While enabled it counts up every cycle
//   and reports the cycle in which the count equals the terminal value div.
//   In that cycle the count reloads to zero, so one tick period is div+1
//   clock cycles. Meant for reuse by scanners, blinkers and debouncers.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset, clears the count
//   clr   in   synchronous clear; wins over en and suppresses tick
//   en    in   count enable
//   div   in   terminal count (DIV_W bits)
//   tick  out  high in the cycle the count matches div (combinational
//              from the count register and div; the user registers it)
//
// Notes:
//   div may change at any time. It is only consulted at the compare, so a
//   new value takes effect at the next compare. If the count is already
//   above the new div it keeps counting, wraps at 2**DIV_W and then matches.
// -----------------------------------------------------------------------------
module tick_prescaler #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;
   logic             match;

   assign match = (cnt_q == div);
   assign tick  = en & ~clr & match;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         // The natural DIV_W-bit overflow gives the wrap at 2**DIV_W.
         cnt_d = match ? '0 : cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : tick_prescaler

// File: rtl/seq_onehot_decoder.sv
// -----------------------------------------------------------------------------
// seq_onehot_decoder
//
// Purpose:
//   Registered SEL_W-to-2**SEL_W one-hot decoder with two modes:
//     direct - decodes the external select every cycle (one-cycle latency)
//     scan   - free-runs an internal index over all outputs, advancing once
//              every div+1 cycles, up or down, for digit/row scanning.
//   With ACTIVE_LOW=1 the output is one-cold (selected line 0, others 1).
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   en           in   block enable; 0 drives the outputs inactive
//   mode         in   0 = direct decode, 1 = scan
//   sel          in   direct-mode index; start index when scan is entered
//   div          in   scan prescaler terminal count
//   dir          in   scan direction: 0 = increment, 1 = decrement
//   d            out  decoded one-hot / one-cold output (registered)
//   idx          out  index currently driving d (registered)
//   valid        out  1 when d holds a decoded value (registered)
//   tick         out  one-cycle pulse in the cycle d moves to a new scan
//                     index (registered)
//   state_dbg_o  out  current control state (state_t encoding)
//
// Interface timing:
//   There is no handshake. Inputs are sampled on every rising edge and all
//   outputs are registered, so every output reflects the inputs seen at the
//   previous edge and no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module seq_onehot_decoder
   import seq_decoder_pkg::*;
#(
   parameter int SEL_W      = 2,
   parameter int DIV_W      = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic [DIV_W-1:0]      div,
   input  logic                  dir,
   output logic [(1<<SEL_W)-1:0] d,
   output logic [SEL_W-1:0]      idx,
   output logic                  valid,
   output logic                  tick,
   output logic [1:0]            state_dbg_o
);

   localparam int OUT_N = 1 << SEL_W;

   // XOR mask applied to the raw one-hot value; also the inactive level.
   localparam logic [OUT_N-1:0] POL_MASK = {OUT_N{ACTIVE_LOW}};

   // ---------------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------------
   state_t state_q;
   state_t state_d;

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else if (mode == MODE_SCAN) begin
         state_d = SCAN;
      end else begin
         state_d = DIRECT;
      end
   end

   // Scan continues only when we were already scanning and stay scanning;
   // any other way into SCAN is an entry, which reloads from sel and
   // restarts the prescaler.
   logic scan_hold;
   assign scan_hold = (state_q == SCAN) && (state_d == SCAN);

   // ---------------------------------------------------------------------------
   // Scan prescaler: counts only while scanning continues, cleared otherwise
   // (idle, direct, and the scan entry cycle).
   // ---------------------------------------------------------------------------
   logic presc_tick;

   tick_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (~scan_hold),
      .en   (scan_hold),
      .div  (div),
      .tick (presc_tick)
   );

   // ---------------------------------------------------------------------------
   // Output registers
   // ---------------------------------------------------------------------------
   logic [OUT_N-1:0] d_q, d_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             tick_q, tick_d;

   // OUT_N is exactly 2**SEL_W, so SEL_W-bit wrap is the required modulo.
   logic [SEL_W-1:0] idx_step;
   assign idx_step = (dir == DIR_DOWN) ? idx_q - SEL_W'(1) : idx_q + SEL_W'(1);

   logic [OUT_N-1:0] onehot;

   always_comb begin
      idx_d   = idx_q;
      valid_d = 1'b0;
      tick_d  = 1'b0;
      onehot  = '0;

      unique case (state_d)
         IDLE: begin
            // idx keeps its last value while idle.
            idx_d = idx_q;
         end
         DIRECT: begin
            idx_d   = sel;
            valid_d = 1'b1;
         end
         SCAN: begin
            valid_d = 1'b1;
            if (!scan_hold) begin
               idx_d = sel;
            end else if (presc_tick) begin
               idx_d  = idx_step;
               tick_d = 1'b1;
            end
         end
         default: begin
            idx_d = idx_q;
         end
      endcase

      if (valid_d) begin
         onehot = OUT_N'(1) << idx_d;
      end
      d_d = onehot ^ POL_MASK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         d_q     <= POL_MASK;
         idx_q   <= '0;
         valid_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         tick_q  <= tick_d;
      end
   end

   assign d           = d_q;
   assign idx         = idx_q;
   assign valid       = valid_q;
   assign tick        = tick_q;
   assign state_dbg_o = state_q;

endmodule : seq_onehot_decoder

// File: doc/seq_onehot_decoder.md
Name: seq_onehot_decoder

Overview:
Parametrised, registered successor to the team's 2-to-4 AND decoder. It converts a SEL_W-bit index into a 2**SEL_W one-hot output and has two modes. Direct mode decodes the external select. Scan mode free-runs an internal index through all outputs at a programmable rate, for display-digit and row scanning. It sits between control logic and board-level enables such as 7-segment digit selects and LED rows.

Parameters:
SEL_W, 2, select/index width; output count OUT_N = 2**SEL_W (derived localparam)
DIV_W, 4, prescaler width; scan step period is div+1 clock cycles
ACTIVE_LOW, 0, 1 = outputs inverted (selected line 0, others 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  block enable; 0 forces outputs inactive
mode  input  1  0 = direct decode, 1 = scan
sel  input  SEL_W  index used in direct mode; start index on scan entry
div  input  DIV_W  scan prescaler terminal count
dir  input  1  scan direction: 0 = increment, 1 = decrement
d  output  OUT_N  decoded one-hot (or one-cold) output, registered
idx  output  SEL_W  index currently driving d
valid  output  1  1 when d holds a decoded value
tick  output  1  one-cycle pulse on each scan index advance

Behaviour:
- Reset (async assert, sync release): state=IDLE, d = all-inactive (0s, or all 1s if ACTIVE_LOW), idx=0, valid=0, tick=0, prescaler=0.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, DIRECT, SCAN.
  - Any state with en=0 goes to IDLE.
  - IDLE with en=1 goes to DIRECT if mode=0, or SCAN if mode=1.
  - DIRECT with mode=1 goes to SCAN; SCAN with mode=0 goes to DIRECT.
- IDLE: d inactive, valid=0, tick=0. idx holds its last value.
- DIRECT: each cycle idx<=sel, d<=onehot(sel), valid<=1. Latency is one cycle from sel to d. tick=0.
- SCAN entry (from IDLE or DIRECT): idx<=sel, d<=onehot(sel), prescaler<=0, valid<=1, tick=0.
- In SCAN, the prescaler increments each cycle.
  - When prescaler==div: prescaler<=0, idx<=idx+1 (dir=0) or idx-1 (dir=1) modulo OUT_N, d follows the new idx, and tick=1 in the same cycle d changes.
  - div=0: idx advances every cycle and tick stays high continuously.
- Wrap-around: OUT_N-1 goes to 0 when incrementing; 0 goes to OUT_N-1 when decrementing.
- div changed mid-scan: takes effect at the next compare. If the prescaler is already above the new div, it continues counting, wraps at 2**DIV_W, then matches.
- dir changed mid-scan: applies at the next advance. The prescaler is not cleared.
- sel changes while in SCAN are ignored.
- en deasserted mid-scan: next cycle d is inactive, valid=0, tick=0, and the prescaler is cleared.
- Invariant: popcount of active bits in d is exactly 1 when valid=1 and 0 when valid=0.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously).

Decomposition:
- Shared package seq_decoder_pkg:
  - state enum (IDLE, DIRECT, SCAN)
  - mode constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1
  - DIR_UP=1'b0, DIR_DOWN=1'b1
- One sub-module: tick_prescaler.
  - Ports: clk, rst, clr, en, div, tick.
  - DIV_W-bit counter that pulses tick on terminal count.
  - Reusable by the team's future blinkers and debouncers.
- Decode and polarity stay in the top level.

Test Plan:
- Reset, then en=1, mode=0, SEL_W=2, sel sweeps 0..3 one per cycle: d = 0001, 0010, 0100, 1000, each one cycle after sel; valid=1.
- mode=1, sel=2, div=3, dir=0: d = 0100 for 4 cycles, then 1000, 0001, 0010; tick pulses every 4th cycle, coincident with each change.
- Scan with div=0, dir=1, start sel=0: d = 0001, 1000, 0100, 0010, 0001; tick held at 1.
- Mid-scan en=0 for 2 cycles, then en=1 with sel=1: d = 0000 and valid=0 while disabled; re-entry gives d=0010 and a full div+1 wait before the next advance.
- ACTIVE_LOW=1 build, direct sel=3: d=0111. Reset asserted between clock edges mid-scan: d=1111, idx=0, valid=0, without waiting for a clock edge.
- SEL_W=3, DIV_W=2, div=1 up-scan from 7: idx = 7, 7, 0, 0, 1. Check the one-hot invariant every cycle.
